// File: rtl/rv32i_lsu_if.sv
// rtl/rv32i_lsu_if.sv - data-memory request/grant port shared by the LSU and its memory
//
// Purpose: bundles the LSU data-memory port into one interface.
// Signals:
//   dm_req   LSU -> mem  request, held until dm_gnt
//   dm_we    LSU -> mem  1 = write
//   dm_addr  LSU -> mem  word-aligned address
//   dm_be    LSU -> mem  byte enables
//   dm_wdat  LSU -> mem  lane-replicated store data
//   dm_gnt   mem -> LSU  request accepted this cycle
//   dm_rvld  mem -> LSU  read data valid
//   dm_rdat  mem -> LSU  read data
// Modports: master (LSU side), slave (memory side).
interface rv32i_lsu_if;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [3:0]  dm_be;
  logic [31:0] dm_wdat;
  logic        dm_gnt;
  logic        dm_rvld;
  logic [31:0] dm_rdat;

  modport master (
    output dm_req, dm_we, dm_addr, dm_be, dm_wdat,
    input  dm_gnt, dm_rvld, dm_rdat
  );

  modport slave (
    input  dm_req, dm_we, dm_addr, dm_be, dm_wdat,
    output dm_gnt, dm_rvld, dm_rdat
  );
endinterface

// File: rtl/rv32i_lsu.sv
// rtl/rv32i_lsu.sv - RV32I load/store unit with request/grant data-memory port
//
// Purpose: takes one load/store at a time from the execute stage, drives the
// data-memory port with byte enables and replicated store data, formats load
// data (lane select + sign/zero extension) for write-back, and flags
// misaligned accesses and bus timeouts.
// Optional feature macro: LSU_MISALIGN_CHK_EN (defined = misalignment check on).
// Parameter:
//   BUS_TOUT   cycles allowed in REQ or WAIT before aborting (0 = no timeout, max 255)
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   ex_vld_i/ex_rdy_o  op handshake from execute (ready only in IDLE)
//   ex_ld_i            1 = load, 0 = store
//   ex_f3_i            funct3 width/sign code
//   ex_addr_i          byte address
//   ex_wdat_i          store data (rs2)
//   ex_rd_i            load destination register
//   dm                 data-memory port (master side)
//   wb_vld_o           one-cycle load result pulse
//   wb_rd_o, wb_dat_o  destination register and formatted load data
//   mis_exc_o          one-cycle misaligned-access pulse
//   bus_err_o          one-cycle timeout pulse
//   err_addr_o         byte address of the faulting op
module rv32i_lsu #(
  parameter int BUS_TOUT = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ex_vld_i,
  output logic               ex_rdy_o,
  input  logic               ex_ld_i,
  input  logic [2:0]         ex_f3_i,
  input  logic [31:0]        ex_addr_i,
  input  logic [31:0]        ex_wdat_i,
  input  logic [4:0]         ex_rd_i,
  rv32i_lsu_if.master        dm,
  output logic               wb_vld_o,
  output logic [4:0]         wb_rd_o,
  output logic [31:0]        wb_dat_o,
  output logic               mis_exc_o,
  output logic               bus_err_o,
  output logic [31:0]        err_addr_o
);

  localparam bit         TOUT_EN   = (BUS_TOUT != 0);
  localparam logic [7:0] TOUT_LAST = 8'(BUS_TOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_e;

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        ld_q;
  logic [2:0]  f3_q;
  logic [31:0] addr_q;
  logic [4:0]  rd_q;
  logic        we_q;
  logic [3:0]  be_q;
  logic [31:0] wdat_q;
  logic        wb_vld_q;
  logic [4:0]  wb_rd_q;
  logic [31:0] wb_dat_q;
  logic        mis_q;
  logic        berr_q;
  logic [31:0] eaddr_q;

  // Decode of the op presented by execute.
  logic        in_byte, in_half, in_mis;
  logic [3:0]  in_be;
  logic [31:0] in_wdat;

  always_comb begin
    in_byte = (ex_f3_i[1:0] == 2'b00);
    in_half = (ex_f3_i[1:0] == 2'b01);
    in_be   = 4'b1111;
    in_wdat = ex_wdat_i;
    if (in_byte) begin
      in_be   = 4'b0001 << ex_addr_i[1:0];
      in_wdat = {4{ex_wdat_i[7:0]}};
    end else if (in_half) begin
      in_be   = ex_addr_i[1] ? 4'b1100 : 4'b0011;
      in_wdat = {2{ex_wdat_i[15:0]}};
    end
`ifdef LSU_MISALIGN_CHK_EN
    in_mis = (in_half && ex_addr_i[0]) ||
             (!in_byte && !in_half && (ex_addr_i[1:0] != 2'b00));
`else
    in_mis = 1'b0;
`endif
  end

  // Load formatting: the lane is the one the byte enables selected, so a
  // half uses addr[1] only and a word always starts at lane 0.
  logic [1:0]  ld_lane;
  logic [31:0] ld_sh, ld_fmt;

  always_comb begin
    case (f3_q[1:0])
      2'b00:   ld_lane = addr_q[1:0];
      2'b01:   ld_lane = {addr_q[1], 1'b0};
      default: ld_lane = 2'b00;
    endcase
    ld_sh = dm.dm_rdat >> {ld_lane, 3'b000};
    case (f3_q[1:0])
      2'b00:   ld_fmt = {{24{~f3_q[2] & ld_sh[7]}}, ld_sh[7:0]};
      2'b01:   ld_fmt = {{16{~f3_q[2] & ld_sh[15]}}, ld_sh[15:0]};
      default: ld_fmt = ld_sh;
    endcase
  end

  logic accept, go_req, wb_set, berr_set, tout;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + 8'd1;
    accept   = 1'b0;
    go_req   = 1'b0;
    wb_set   = 1'b0;
    berr_set = 1'b0;
    tout     = TOUT_EN && (cnt_q == TOUT_LAST);
    case (state_q)
      S_IDLE: begin
        cnt_d = 8'd0;
        if (ex_vld_i) begin
          accept = 1'b1;
          if (!in_mis) begin
            go_req  = 1'b1;
            state_d = S_REQ;
          end
        end
      end
      S_REQ: begin
        if (dm.dm_gnt) begin
          state_d = ld_q ? S_WAIT : S_IDLE;
          cnt_d   = 8'd0;
        end else if (tout) begin
          state_d  = S_IDLE;
          berr_set = 1'b1;
        end
      end
      S_WAIT: begin
        if (dm.dm_rvld) begin
          state_d = S_IDLE;
          wb_set  = 1'b1;
        end else if (tout) begin
          state_d  = S_IDLE;
          berr_set = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= 8'd0;
      ld_q     <= 1'b0;
      f3_q     <= 3'd0;
      addr_q   <= 32'd0;
      rd_q     <= 5'd0;
      we_q     <= 1'b0;
      be_q     <= 4'd0;
      wdat_q   <= 32'd0;
      wb_vld_q <= 1'b0;
      wb_rd_q  <= 5'd0;
      wb_dat_q <= 32'd0;
      mis_q    <= 1'b0;
      berr_q   <= 1'b0;
      eaddr_q  <= 32'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      wb_vld_q <= wb_set;
      mis_q    <= accept & in_mis;
      berr_q   <= berr_set;
      // Bus-side registers only move for ops that actually reach the bus.
      if (go_req) begin
        ld_q   <= ex_ld_i;
        f3_q   <= ex_f3_i;
        addr_q <= ex_addr_i;
        rd_q   <= ex_rd_i;
        we_q   <= ~ex_ld_i;
        be_q   <= in_be;
        wdat_q <= in_wdat;
      end
      if (accept & in_mis) begin
        eaddr_q <= ex_addr_i;
      end else if (berr_set) begin
        eaddr_q <= addr_q;
      end
      if (wb_set) begin
        wb_rd_q  <= rd_q;
        wb_dat_q <= ld_fmt;
      end
    end
  end

  assign ex_rdy_o   = (state_q == S_IDLE);
  assign dm.dm_req  = (state_q == S_REQ);
  assign dm.dm_we   = we_q;
  assign dm.dm_addr = {addr_q[31:2], 2'b00};
  assign dm.dm_be   = be_q;
  assign dm.dm_wdat = wdat_q;
  assign wb_vld_o   = wb_vld_q;
  assign wb_rd_o    = wb_rd_q;
  assign wb_dat_o   = wb_dat_q;
  assign mis_exc_o  = mis_q;
  assign bus_err_o  = berr_q;
  assign err_addr_o = eaddr_q;

endmodule

// File: tb/tb_rv32i_lsu.sv
// tb/tb_rv32i_lsu.sv - self-checking bench for rv32i_lsu
module tb_rv32i_lsu;
  localparam int TOUT = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ex_vld = 1'b0;
  logic        ex_rdy;
  logic        ex_ld = 1'b0;
  logic [2:0]  ex_f3 = 3'd0;
  logic [31:0] ex_addr = 32'd0;
  logic [31:0] ex_wdat = 32'd0;
  logic [4:0]  ex_rd = 5'd0;
  logic        wb_vld;
  logic [4:0]  wb_rd;
  logic [31:0] wb_dat;
  logic        mis_exc;
  logic        bus_err;
  logic [31:0] err_addr;

  rv32i_lsu_if dm();

  rv32i_lsu #(.BUS_TOUT(TOUT)) dut (
    .clk        (clk),
    .rst        (rst),
    .ex_vld_i   (ex_vld),
    .ex_rdy_o   (ex_rdy),
    .ex_ld_i    (ex_ld),
    .ex_f3_i    (ex_f3),
    .ex_addr_i  (ex_addr),
    .ex_wdat_i  (ex_wdat),
    .ex_rd_i    (ex_rd),
    .dm         (dm),
    .wb_vld_o   (wb_vld),
    .wb_rd_o    (wb_rd),
    .wb_dat_o   (wb_dat),
    .mis_exc_o  (mis_exc),
    .bus_err_o  (bus_err),
    .err_addr_o (err_addr)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit chk_on = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int nbytes(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return 1;
      2'b01:   return 2;
      default: return 4;
    endcase
  endfunction

  // First lane of the access: byte address within the word, aligned down to the size.
  function automatic int base_lane(input logic [2:0] f3, input logic [31:0] addr);
    int n = nbytes(f3);
    return (int'(addr[1:0]) / n) * n;
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] addr);
    logic [3:0] be = 4'd0;
    int n = nbytes(f3);
    int b = base_lane(f3, addr);
    for (int i = 0; i < 4; i++) be[i] = (i >= b) && (i < b + n);
    return be;
  endfunction

  function automatic logic [31:0] m_wdat(input logic [2:0] f3, input logic [31:0] wdat);
    logic [31:0] o = 32'd0;
    int n = nbytes(f3);
    for (int i = 0; i < 4; i++) o[8*i +: 8] = wdat[8*(i % n) +: 8];
    return o;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] addr,
                                         input logic [31:0] rdat);
    int n = nbytes(f3);
    int b = base_lane(f3, addr);
    longint v = 0;
    for (int k = 0; k < n; k++) v += longint'(rdat[8*(b+k) +: 8]) << (8*k);
    if (!f3[2] && n < 4 && v >= (longint'(1) << (8*n - 1))) v -= longint'(1) << (8*n);
    return v[31:0];
  endfunction

  function automatic bit misal(input logic [2:0] f3, input logic [31:0] addr);
`ifdef LSU_MISALIGN_CHK_EN
    return (int'(addr[1:0]) % nbytes(f3)) != 0;
`else
    return 1'b0;
`endif
  endfunction

  bit          m_idle = 1'b1, m_req = 1'b0, m_await = 1'b0;
  int          m_cnt = 0;
  logic        m_ld = 1'b0;
  logic [2:0]  m_f3 = 3'd0;
  logic [31:0] m_addr = 32'd0, m_wdat_op = 32'd0;
  logic [4:0]  m_rd = 5'd0;
  bit          m_wb = 1'b0, m_mis = 1'b0, m_berr = 1'b0;
  logic [4:0]  m_wbrd = 5'd0;
  logic [31:0] m_wbdat = 32'd0, m_eaddr = 32'd0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_idle <= 1'b1; m_req <= 1'b0; m_await <= 1'b0; m_cnt <= 0;
      m_wb <= 1'b0; m_mis <= 1'b0; m_berr <= 1'b0;
    end else begin
      m_wb <= 1'b0; m_mis <= 1'b0; m_berr <= 1'b0;
      if (m_idle) begin
        if (ex_vld) begin
          if (misal(ex_f3, ex_addr)) begin
            m_mis <= 1'b1; m_eaddr <= ex_addr;
          end else begin
            m_idle <= 1'b0; m_req <= 1'b1; m_cnt <= 0;
            m_ld <= ex_ld; m_f3 <= ex_f3; m_addr <= ex_addr; m_wdat_op <= ex_wdat; m_rd <= ex_rd;
          end
        end
      end else if (m_req) begin
        if (dm.dm_gnt) begin
          m_req <= 1'b0; m_cnt <= 0;
          if (m_ld) m_await <= 1'b1; else m_idle <= 1'b1;
        end else if (m_cnt + 1 == TOUT) begin
          m_req <= 1'b0; m_idle <= 1'b1; m_berr <= 1'b1; m_eaddr <= m_addr;
        end else m_cnt <= m_cnt + 1;
      end else if (m_await) begin
        if (dm.dm_rvld) begin
          m_await <= 1'b0; m_idle <= 1'b1; m_wb <= 1'b1;
          m_wbrd <= m_rd; m_wbdat <= m_load(m_f3, m_addr, dm.dm_rdat);
        end else if (m_cnt + 1 == TOUT) begin
          m_await <= 1'b0; m_idle <= 1'b1; m_berr <= 1'b1; m_eaddr <= m_addr;
        end else m_cnt <= m_cnt + 1;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_on) begin
      chk("ex_rdy", 32'(ex_rdy), 32'(m_idle));
      chk("dm_req", 32'(dm.dm_req), 32'(m_req));
      if (m_req) begin
        chk("dm_addr", dm.dm_addr, m_addr - (m_addr % 4));
        chk("dm_we", 32'(dm.dm_we), 32'(!m_ld));
        chk("dm_be", 32'(dm.dm_be), 32'(m_be(m_f3, m_addr)));
        if (!m_ld) chk("dm_wdat", dm.dm_wdat, m_wdat(m_f3, m_wdat_op));
      end
      chk("wb_vld", 32'(wb_vld), 32'(m_wb));
      if (m_wb) begin
        chk("wb_rd", 32'(wb_rd), 32'(m_wbrd));
        chk("wb_dat", wb_dat, m_wbdat);
      end
      chk("mis_exc", 32'(mis_exc), 32'(m_mis));
      chk("bus_err", 32'(bus_err), 32'(m_berr));
      if (m_mis || m_berr) chk("err_addr", err_addr, m_eaddr);
    end
  end

  // ---------------- observer of actual DUT activity ----------------
  int          o_wb_n = 0, o_req_n = 0, o_mis_n = 0, o_berr_n = 0;
  int          o_wb_cyc = 0, o_mis_cyc = 0, o_berr_cyc = 0;
  logic [31:0] o_wb_dat = 32'd0, o_addr = 32'd0, o_wdat = 32'd0, o_eaddr = 32'd0;
  logic [4:0]  o_wb_rd = 5'd0;
  logic [3:0]  o_be = 4'd0;

  always @(negedge clk) begin
    if (wb_vld) begin o_wb_n++; o_wb_dat = wb_dat; o_wb_rd = wb_rd; o_wb_cyc = cyc; end
    if (dm.dm_req) begin o_req_n++; o_be = dm.dm_be; o_addr = dm.dm_addr; o_wdat = dm.dm_wdat; end
    if (mis_exc) begin o_mis_n++; o_mis_cyc = cyc; o_eaddr = err_addr; end
    if (bus_err) begin o_berr_n++; o_berr_cyc = cyc; o_eaddr = err_addr; end
  end

  // ---------------- stimulus ----------------
  int acc_cyc = 0;

  task automatic present(input logic ld, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdat, input logic [4:0] rd);
    @(negedge clk);
    ex_vld = 1'b1; ex_ld = ld; ex_f3 = f3; ex_addr = addr; ex_wdat = wdat; ex_rd = rd;
    acc_cyc = cyc;
    @(negedge clk);
    ex_vld = 1'b0;
  endtask

  // gdly/rdly < 0 means the memory never answers that phase.
  task automatic run_op(input logic ld, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdat, input logic [4:0] rd,
                        input int gdly, input int rdly, input logic [31:0] rdat);
    present(ld, f3, addr, wdat, rd);
    if (gdly >= 0) begin
      repeat (gdly) @(negedge clk);
      dm.dm_gnt = 1'b1;
      @(negedge clk);
      dm.dm_gnt = 1'b0;
      if (ld && rdly >= 0) begin
        repeat (rdly) @(negedge clk);
        dm.dm_rvld = 1'b1; dm.dm_rdat = rdat;
        @(negedge clk);
        dm.dm_rvld = 1'b0; dm.dm_rdat = 32'h5A5A_A5A5;
      end
    end
    repeat (3) @(negedge clk);
  endtask

  int wb0, req0, mis0, berr0;

  task automatic snap();
    wb0 = o_wb_n; req0 = o_req_n; mis0 = o_mis_n; berr0 = o_berr_n;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1);
  end

  initial begin
    dm.dm_gnt = 1'b0; dm.dm_rvld = 1'b0; dm.dm_rdat = 32'd0;
    repeat (2) @(negedge clk);
    // reset values while reset is held
    chk("rst ex_rdy", 32'(ex_rdy), 32'd1);
    chk("rst dm_req", 32'(dm.dm_req), 32'd0);
    chk("rst dm_we", 32'(dm.dm_we), 32'd0);
    chk("rst dm_addr", dm.dm_addr, 32'd0);
    chk("rst dm_be", 32'(dm.dm_be), 32'd0);
    chk("rst dm_wdat", dm.dm_wdat, 32'd0);
    chk("rst wb_vld", 32'(wb_vld), 32'd0);
    chk("rst wb_rd", 32'(wb_rd), 32'd0);
    chk("rst wb_dat", wb_dat, 32'd0);
    chk("rst mis_exc", 32'(mis_exc), 32'd0);
    chk("rst bus_err", 32'(bus_err), 32'd0);
    chk("rst err_addr", err_addr, 32'd0);
    rst = 1'b0;
    chk_on = 1'b1;
    @(negedge clk);
    chk("post-rst ex_rdy", 32'(ex_rdy), 32'd1);

    // LW 0x100, zero-wait
    snap();
    run_op(1'b1, 3'b010, 32'h100, 32'd0, 5'd7, 0, 0, 32'hDEAD_BEEF);
    chk("lw wb_dat", o_wb_dat, 32'hDEAD_BEEF);
    chk("lw wb_rd", 32'(o_wb_rd), 32'd7);
    chk("lw be", 32'(o_be), 32'hF);
    chk("lw wb cycle", 32'(o_wb_cyc - acc_cyc), 32'd3);
    chk("lw wb count", 32'(o_wb_n - wb0), 32'd1);

    // LB / LBU 0x103
    run_op(1'b1, 3'b000, 32'h103, 32'd0, 5'd3, 0, 0, 32'h8012_3456);
    chk("lb be", 32'(o_be), 32'h8);
    chk("lb wb_dat", o_wb_dat, 32'hFFFF_FF80);
    run_op(1'b1, 3'b100, 32'h103, 32'd0, 5'd3, 1, 2, 32'h8012_3456);
    chk("lbu wb_dat", o_wb_dat, 32'h0000_0080);

    // LH / LHU
    run_op(1'b1, 3'b001, 32'h102, 32'd0, 5'd9, 0, 1, 32'h8001_7FFF);
    chk("lh wb_dat", o_wb_dat, 32'hFFFF_8001);
    run_op(1'b1, 3'b101, 32'h100, 32'd0, 5'd9, 0, 0, 32'h1234_F00F);
    chk("lhu wb_dat", o_wb_dat, 32'h0000_F00F);

    // SH 0x202, grant delayed 3 cycles
    snap();
    run_op(1'b0, 3'b001, 32'h202, 32'h0000_ABCD, 5'd0, 3, 0, 32'd0);
    chk("sh req cycles", 32'(o_req_n - req0), 32'd4);
    chk("sh be", 32'(o_be), 32'hC);
    chk("sh wdat", o_wdat, 32'hABCD_ABCD);
    chk("sh addr", o_addr, 32'h200);
    chk("sh no wb", 32'(o_wb_n - wb0), 32'd0);

    // SB / SW, zero-wait
    run_op(1'b0, 3'b000, 32'h301, 32'h1234_565A, 5'd0, 0, 0, 32'd0);
    chk("sb be", 32'(o_be), 32'h2);
    chk("sb wdat", o_wdat, 32'h5A5A_5A5A);
    run_op(1'b0, 3'b010, 32'h304, 32'h0BAD_F00D, 5'd0, 0, 0, 32'd0);
    chk("sw wdat", o_wdat, 32'h0BAD_F00D);

    // load to x0 still pulses wb_vld
    snap();
    run_op(1'b1, 3'b010, 32'h10, 32'd0, 5'd0, 0, 0, 32'h1111_2222);
    chk("x0 wb count", 32'(o_wb_n - wb0), 32'd1);
    chk("x0 wb_rd", 32'(o_wb_rd), 32'd0);

    // LW 0x101: misaligned
    snap();
    run_op(1'b1, 3'b010, 32'h101, 32'd0, 5'd4, 0, 0, 32'hCAFE_F00D);
`ifdef LSU_MISALIGN_CHK_EN
    chk("mis count", 32'(o_mis_n - mis0), 32'd1);
    chk("mis cycle", 32'(o_mis_cyc - acc_cyc), 32'd1);
    chk("mis err_addr", o_eaddr, 32'h101);
    chk("mis no req", 32'(o_req_n - req0), 32'd0);
    chk("mis no wb", 32'(o_wb_n - wb0), 32'd0);
`else
    chk("unchk no mis", 32'(o_mis_n - mis0), 32'd0);
    chk("unchk be", 32'(o_be), 32'hF);
    chk("unchk addr", o_addr, 32'h100);
    chk("unchk wb_dat", o_wb_dat, 32'hCAFE_F00D);
`endif

    // Timeout in WAIT: gnt then no rvld
    snap();
    run_op(1'b1, 3'b010, 32'h400, 32'd0, 5'd6, 0, -1, 32'd0);
    repeat (4) @(negedge clk);
    chk("tout wait count", 32'(o_berr_n - berr0), 32'd1);
    chk("tout wait cycle", 32'(o_berr_cyc - acc_cyc), 32'd6);
    chk("tout wait addr", o_eaddr, 32'h400);
    chk("tout idle", 32'(ex_rdy), 32'd1);
    dm.dm_rvld = 1'b1; dm.dm_rdat = 32'h7777_7777;
    @(negedge clk);
    dm.dm_rvld = 1'b0;
    repeat (2) @(negedge clk);
    chk("late rvld no wb", 32'(o_wb_n - wb0), 32'd0);

    // Timeout in REQ: never granted, late gnt ignored
    snap();
    run_op(1'b0, 3'b010, 32'h504, 32'h1, 5'd0, -1, -1, 32'd0);
    repeat (4) @(negedge clk);
    chk("tout req cycle", 32'(o_berr_cyc - acc_cyc), 32'd5);
    chk("tout req cycles", 32'(o_req_n - req0), 32'd4);
    dm.dm_gnt = 1'b1;
    @(negedge clk);
    dm.dm_gnt = 1'b0;
    @(negedge clk);
    chk("late gnt idle", 32'(ex_rdy), 32'd1);

    // Reset while in REQ
    present(1'b1, 3'b010, 32'h600, 32'd0, 5'd2);
    chk("req before rst", 32'(dm.dm_req), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("rst req drop", 32'(dm.dm_req), 32'd0);
    chk("rst req rdy", 32'(ex_rdy), 32'd1);
    @(negedge clk);
    rst = 1'b0;

    // Reset while in WAIT, late rvld afterwards
    snap();
    present(1'b1, 3'b010, 32'h700, 32'd0, 5'd2);
    dm.dm_gnt = 1'b1;
    @(negedge clk);
    dm.dm_gnt = 1'b0;
    chk("in wait rdy", 32'(ex_rdy), 32'd0);
    #2 rst = 1'b1;
    #1;
    chk("rst wait req", 32'(dm.dm_req), 32'd0);
    chk("rst wait wb", 32'(wb_vld), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    dm.dm_rvld = 1'b1;
    @(negedge clk);
    dm.dm_rvld = 1'b0;
    @(negedge clk);
    chk("rst wait rdy after", 32'(ex_rdy), 32'd1);
    chk("rst wait no wb", 32'(o_wb_n - wb0), 32'd0);
    chk("rst wait no err", 32'(o_berr_n - berr0), 32'd0);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/rv32i_lsu.md
# rv32i_lsu

Load/store unit sitting directly downstream of the RV32I execute stage. Accepts one memory operation at a time, using the execute stage's computed data-memory address and rs2 store data. Drives a request/grant data-memory port with byte enables and formats load data (alignment, sign/zero extension) for write-back. Also flags misaligned accesses and bus timeouts.

## Interface
Parameters:
- BUS_TOUT, 16: cycles to wait in REQ or WAIT before aborting; 0 disables the timeout; max 255.

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- ex_vld  in  1  memory op presented
- ex_rdy  out  1  LSU can accept (high only in IDLE)
- ex_ld  in  1  1 = load, 0 = store
- ex_f3  in  3  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
- ex_addr  in  32  byte address (execute-stage rs1+offset result)
- ex_wdat  in  32  store data (rs2)
- ex_rd  in  5  load destination register
- dm_req  out  1  memory request, held until grant
- dm_we  out  1  1 = write
- dm_addr  out  32  word address, {ex_addr[31:2],2'b00}
- dm_be  out  4  byte enables
- dm_wdat  out  32  lane-replicated store data
- dm_gnt  in  1  request accepted this cycle
- dm_rvld  in  1  read data valid
- dm_rdat  in  32  read data
- wb_vld  out  1  one-cycle load result pulse
- wb_rd  out  5  destination register
- wb_dat  out  32  formatted load data
- mis_exc  out  1  one-cycle misaligned-access pulse
- bus_err  out  1  one-cycle timeout pulse
- err_addr  out  32  byte address of the faulting op

## Operation
- States: IDLE, REQ, WAIT.
- IDLE:
  - ex_rdy=1.
  - On ex_vld, capture addr, f3, ld, wdat, rd.
  - If misaligned (H with addr[0]=1; W with addr[1:0]!=0): mis_exc pulses next cycle, err_addr=addr, stay IDLE, no bus activity.
  - Otherwise go to REQ.
- REQ:
  - dm_req=1; dm_we, dm_addr, dm_be, dm_wdat stable until dm_gnt.
  - On dm_gnt, a store returns to IDLE and a load goes to WAIT.
  - dm_rvld is ignored in REQ.
- WAIT:
  - On dm_rvld, register the formatted data: wb_vld=1 for exactly one cycle, return to IDLE.
- Width decode:
  - f3[1:0]=00 is byte, 01 is half, 1x is word.
  - f3[2]=1 zero-extends; f3[2] is ignored for word.
  - 011/110/111 act as word.
- Byte enables:
  - Byte: be = 4'b0001 << addr[1:0].
  - Half: be = addr[1] ? 1100 : 0011.
  - Word: be = 1111.
- Store data: byte = {4{wdat[7:0]}}, half = {2{wdat[15:0]}}, word = wdat.
- Load format:
  - Shift dm_rdat right by 8*addr[1:0], take 8/16/32 bits.
  - Sign-extend unless f3[2]=1.
- rd=0 loads run normally; wb_vld still pulses with wb_rd=0.
- Timeout: an 8-bit counter clears on entry to REQ/WAIT and increments each cycle there. When it reaches BUS_TOUT (nonzero):
  - bus_err pulses, err_addr = address, return to IDLE.
  - dm_req drops that same cycle.
  - A late dm_rvld/dm_gnt seen in IDLE is ignored.

## Timing
- Reset values: state=IDLE, dm_req=0, dm_we=0, dm_addr=0, dm_be=0, dm_wdat=0, wb_vld=0, wb_rd=0, wb_dat=0, mis_exc=0, bus_err=0, err_addr=0, ex_rdy=1 after reset release.
- Reset asserted mid-operation: outputs return to reset values immediately (asynchronous), with no wb_vld and no error pulse.
- Handshake: accept at cycle 0 (ex_vld&ex_rdy), dm_req=1 from cycle 1.
- Zero-wait store: gnt at cycle 1, ex_rdy back at cycle 2.
- Zero-wait load: gnt at cycle 1, rvld at cycle 2, wb_vld at cycle 3, ex_rdy at cycle 3.
- Each grant/rvld wait cycle adds one cycle.
- Misaligned op: mis_exc at cycle 1, ex_rdy stays 1 (back-to-back accept allowed).
- dm_gnt while dm_req=0 is ignored.

## Configuration
- LSU_MISALIGN_CHK_EN defined: misalignment is detected as above.
- LSU_MISALIGN_CHK_EN undefined: no check. mis_exc is tied 0, and address low bits still select lanes, with half using addr[1] and word using be=1111. Misaligned accesses proceed as if aligned down.

## Test plan
- LW addr 0x100, gnt cycle 1, rvld cycle 2 with rdat 0xDEADBEEF -> dm_be=1111, wb_vld cycle 3, wb_dat=0xDEADBEEF, wb_rd matches.
- LB addr 0x103, rdat 0x80123456 -> be=1000, wb_dat=0xFFFFFF80. LBU on the same op -> 0x00000080.
- SH addr 0x202, wdat 0x0000ABCD, gnt delayed 3 cycles -> dm_req held 4 cycles, be=1100, dm_wdat=0xABCDABCD, addr/be stable, no wb_vld.
- LW addr 0x101 with LSU_MISALIGN_CHK_EN -> mis_exc at cycle 1, err_addr=0x101, dm_req never asserted.
- Load, gnt given, rvld withheld, BUS_TOUT=4 -> bus_err after 4 WAIT cycles, state IDLE. A later rvld produces no wb_vld.
- rst asserted while in WAIT -> dm_req/wb_vld 0 immediately, ex_rdy=1 after release.
